// File: rtl/ps2_poll_ctrl_pkg.sv
// Shared types and constants for the PS/2 keyboard polling controller.
package ps2_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R
  } state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B      = 3'b010;
  localparam int         AXI_RESP_ERR_BIT = 1;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam int PS2_EVT_W = $bits(ps2_evt_t);

endpackage

// File: rtl/ps2_poll_ctrl_if.sv
// AXI4 read-channel bundle between the poll controller and the keyboard slave.
interface ps2_poll_ctrl_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Small first-word-fall-through FIFO holding decoded key events.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage array is written without reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointers wrap with one extra bit so full and empty are distinguishable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_poll_ctrl.sv
// AXI4 read master that polls the PS/2 slave, decodes set-2 prefixes
// and queues complete key events for the consumer.
module ps2_poll_ctrl
  import ps2_poll_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_3000,
  parameter int          POLL_CYCLES = 1000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [3:0]  ARID        = 4'd0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  ps2_poll_ctrl_if.master io_master,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [7:0]      evt_code,
  output logic            evt_break,
  output logic            evt_ext,
  output logic [7:0]      err_cnt
);

  localparam int TIMER_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_CYCLES - 1);

  state_t               state, state_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic                 drain, drain_next;
  logic                 ext_pend, ext_pend_next;
  logic                 brk_pend, brk_pend_next;
  logic [7:0]           err_q, err_next;
  logic                 push;
  ps2_evt_t             push_evt;
  ps2_evt_t             head_evt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           rbyte;
  logic                 unused_bits;

  assign rbyte = io_master.rdata[7:0];
  assign unused_bits = ^{io_master.rdata[63:8], io_master.rresp[0],
                         io_master.rlast, io_master.rid};

  assign io_master.araddr  = BASE_ADDR;
  assign io_master.arid    = ARID;
  assign io_master.arlen   = 8'd0;
  assign io_master.arsize  = AXI_SIZE_4B;
  assign io_master.arburst = AXI_BURST_INCR;

  // Controller state: FSM, poll timer, drain flag, prefix flags, error counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      timer    <= TIMER_RELOAD;
      drain    <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      err_q    <= 8'd0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      drain    <= drain_next;
      ext_pend <= ext_pend_next;
      brk_pend <= brk_pend_next;
      err_q    <= err_next;
    end
  end

  // Poll sequencing and scan-byte decode; reads are only issued with FIFO room.
  always_comb begin
    state_next         = state;
    timer_next         = timer;
    drain_next         = drain;
    ext_pend_next      = ext_pend;
    brk_pend_next      = brk_pend;
    err_next           = err_q;
    push               = 1'b0;
    push_evt           = '0;
    io_master.arvalid  = 1'b0;
    io_master.rready   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !fifo_full && (drain || timer == '0)) begin
          state_next = ST_AR;
        end else if (timer != '0) begin
          timer_next = timer - 1'b1;
        end
      end
      ST_AR: begin
        io_master.arvalid = 1'b1;
        if (io_master.arready) state_next = ST_R;
      end
      ST_R: begin
        io_master.rready = 1'b1;
        if (io_master.rvalid) begin
          state_next = ST_IDLE;
          if (io_master.rresp[AXI_RESP_ERR_BIT]) begin
            if (err_q != 8'hFF) err_next = err_q + 8'd1;
            drain_next = 1'b0;
            timer_next = TIMER_RELOAD;
          end else if (rbyte == 8'h00) begin
            drain_next = 1'b0;
            timer_next = TIMER_RELOAD;
          end else if (rbyte == PS2_PFX_EXT) begin
            ext_pend_next = 1'b1;
            drain_next    = 1'b1;
          end else if (rbyte == PS2_PFX_BRK) begin
            brk_pend_next = 1'b1;
            drain_next    = 1'b1;
          end else begin
            push          = 1'b1;
            push_evt.ext  = ext_pend;
            push_evt.brk  = brk_pend;
            push_evt.code = rbyte;
            ext_pend_next = 1'b0;
            brk_pend_next = 1'b0;
            drain_next    = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt_valid && evt_ready),
    .pop_data  (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head_evt.code;
  assign evt_break = head_evt.brk;
  assign evt_ext   = head_evt.ext;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_ps2_poll_ctrl.sv
// Directed bench for ps2_poll_ctrl with a one-cycle-latency AXI read slave model.
module tb_ps2_poll_ctrl;

  localparam int POLL = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic [7:0] err_cnt;

  logic       ar_ready_en;
  logic       err_mode;
  logic       slv_pending;
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] byte_q[$];

  int cyc = 0;
  int ar_count = 0;
  int ar_cyc_last = 0;
  int ar_cyc_prev = 0;
  int checks = 0;
  int errors = 0;
  int n0;
  int c0;
  logic [7:0] exp_codes [5];

  ps2_poll_ctrl_if bus ();

  ps2_poll_ctrl #(
    .BASE_ADDR   (32'h1000_3000),
    .POLL_CYCLES (POLL),
    .FIFO_DEPTH  (4),
    .ARID        (4'd0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .io_master (bus),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .err_cnt   (err_cnt)
  );

  assign bus.arready = ar_ready_en;
  assign bus.rvalid  = slv_pending;
  assign bus.rdata   = {56'h0, (err_mode ? 8'h5A : rd_byte)};
  assign bus.rresp   = err_mode ? 2'b10 : 2'b00;
  assign bus.rlast   = 1'b1;
  assign bus.rid     = 4'd0;

  always #5 clock = ~clock;

  // Slave: accept the address, answer with data on the following cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      slv_pending <= 1'b0;
    end else if (bus.arvalid && bus.arready) begin
      slv_pending <= 1'b1;
    end else if (bus.rvalid && bus.rready) begin
      slv_pending <= 1'b0;
      if (!err_mode && byte_q.size() != 0) void'(byte_q.pop_front());
    end
  end

  // Present the slave's head byte, refreshed away from the active edge.
  always @(negedge clock) begin
    rd_byte = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
  end

  // Cycle counter and timestamps of each accepted read address.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.arvalid && bus.arready) begin
      ar_count    <= ar_count + 1;
      ar_cyc_last <= cyc;
      ar_cyc_prev <= ar_cyc_last;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_reads(input int target, input int budget);
    int k = 0;
    while (ar_count < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_output("wait_reads", 64'(ar_count >= target), 64'd1);
    @(negedge clock);
  endtask

  task automatic pop_event();
    evt_ready = 1'b1;
    @(negedge clock);
    evt_ready = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    evt_ready   = 1'b0;
    ar_ready_en = 1'b1;
    err_mode    = 1'b0;
    exp_codes   = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    repeat (3) @(negedge clock);

    $display("[TB] reset state");
    check_output("rst_arvalid", bus.arvalid, 0);
    check_output("rst_rready", bus.rready, 0);
    check_output("rst_evt_valid", evt_valid, 0);
    check_output("rst_evt_fields", {evt_ext, evt_break, evt_code}, 0);
    check_output("rst_err_cnt", err_cnt, 0);

    $display("[TB] idle polling of an empty slave");
    enable = 1'b1;
    reset  = 1'b0;
    c0     = cyc;
    wait_reads(1, 50);
    check_output("first_poll_delay", ar_cyc_last - c0, POLL);
    wait_reads(3, 60);
    check_output("idle_period", ar_cyc_last - ar_cyc_prev, POLL + 2);
    check_output("idle_evt_valid", evt_valid, 0);
    check_output("araddr", bus.araddr, 32'h1000_3000);
    check_output("ar_attrs", {bus.arid, bus.arlen, bus.arsize, bus.arburst},
                 {4'd0, 8'd0, 3'b010, 2'b01});

    $display("[TB] E0 F0 75 sequence");
    byte_q.push_back(8'hE0);
    byte_q.push_back(8'hF0);
    byte_q.push_back(8'h75);
    byte_q.push_back(8'h00);
    n0 = ar_count;
    wait_reads(n0 + 2, 60);
    check_output("pfx_no_event", evt_valid, 0);
    wait_reads(n0 + 3, 20);
    check_output("pfx_evt_valid", evt_valid, 1);
    check_output("pfx_evt", {evt_ext, evt_break, evt_code}, {1'b1, 1'b1, 8'h75});
    pop_event();
    wait_reads(n0 + 4, 20);
    check_output("pfx_drained", evt_valid, 0);

    $display("[TB] 1C then empty");
    byte_q.push_back(8'h1C);
    byte_q.push_back(8'h00);
    n0 = ar_count;
    wait_reads(n0 + 2, 60);
    check_output("drain_gap", ar_cyc_last - ar_cyc_prev, 3);
    check_output("plain_evt_valid", evt_valid, 1);
    check_output("plain_evt", {evt_ext, evt_break, evt_code}, {1'b0, 1'b0, 8'h1C});
    wait_reads(n0 + 3, 60);
    check_output("resume_period", ar_cyc_last - ar_cyc_prev, POLL + 2);
    pop_event();
    check_output("plain_popped", evt_valid, 0);

    $display("[TB] FIFO full backpressure");
    for (int i = 0; i < 6; i++) byte_q.push_back(8'h11 + 8'(i));
    byte_q.push_back(8'h00);
    n0 = ar_count;
    wait_reads(n0 + 4, 80);
    repeat (30) @(negedge clock);
    check_output("full_read_count", ar_count - n0, 4);
    check_output("full_arvalid", bus.arvalid, 0);
    check_output("full_head", {evt_valid, evt_code}, {1'b1, 8'h11});
    pop_event();
    wait_reads(n0 + 5, 20);
    repeat (20) @(negedge clock);
    check_output("refull_read_count", ar_count - n0, 5);
    for (int i = 0; i < 5; i++) begin
      check_output("full_seq_code", {evt_valid, evt_code}, {1'b1, exp_codes[i]});
      pop_event();
      repeat (6) @(negedge clock);
    end
    wait_reads(n0 + 7, 40);
    check_output("full_all_popped", evt_valid, 0);

    $display("[TB] error responses");
    err_mode = 1'b1;
    n0 = ar_count;
    wait_reads(n0 + 1, 40);
    check_output("err_cnt_one", err_cnt, 1);
    check_output("err_no_event", evt_valid, 0);
    wait_reads(n0 + 2, 40);
    check_output("err_timer_reload", ar_cyc_last - ar_cyc_prev, POLL + 2);
    wait_reads(n0 + 301, 4000);
    check_output("err_cnt_sat", err_cnt, 255);
    err_mode = 1'b0;

    $display("[TB] reset during a stalled address phase");
    byte_q.push_back(8'h2A);
    n0 = ar_count;
    wait_reads(n0 + 1, 40);
    check_output("pre_rst_evt", {evt_valid, evt_code}, {1'b1, 8'h2A});
    ar_ready_en = 1'b0;
    @(negedge clock);
    check_output("stall_arvalid", bus.arvalid, 1);
    #2 reset = 1'b1;
    #1;
    check_output("async_arvalid", bus.arvalid, 0);
    check_output("async_evt_valid", evt_valid, 0);
    check_output("async_err_cnt", err_cnt, 0);
    @(negedge clock);
    byte_q.delete();
    ar_ready_en = 1'b1;
    reset = 1'b0;
    c0 = cyc;
    n0 = ar_count;
    wait_reads(n0 + 1, 50);
    check_output("post_rst_delay", ar_cyc_last - c0, POLL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Last-resort guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
